// File: rtl/score_history_store_pkg.sv
// Shared types for the play-record history store: record layout, depth and FSM states.
// The SCORE_HISTORY_BEST_EN build option is handled in score_history_store.sv.
package score_history_store_pkg;

   localparam int HISTORY_DEPTH = 9;

   typedef struct packed {
      logic        valid;
      logic [7:0]  user_id;
      logic [7:0]  chart_id;
      logic [15:0] score;
   } PlayRecord;

   localparam PlayRecord EMPTY_RECORD = '0;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

endpackage

// File: rtl/score_history_store_history_index_map.sv
// Maps a logical record id (1 = newest) onto a physical circular-buffer slot.
// hit_o is low for id 0 or ids beyond the number of stored records.
module history_index_map #(
   parameter int DEPTH = 9,
   parameter int ID_W  = 8
) (
   input  logic [3:0]      wptr_i,
   input  logic [3:0]      count_i,
   input  logic [ID_W-1:0] k_i,
   output logic [3:0]      phys_idx_o,
   output logic            hit_o
);

   logic [ID_W-1:0] count_ext;
   logic [4:0]      diff;

   always_comb begin
      count_ext  = {{(ID_W-4){1'b0}}, count_i};
      hit_o      = (k_i != '0) && (k_i <= count_ext);
      diff       = {1'b0, wptr_i} - {1'b0, k_i[3:0]};
      phys_idx_o = '0;
      // A borrow means the slot sits behind the wrap point, so fold by DEPTH.
      if (hit_o) begin
         phys_idx_o = diff[4] ? (diff[3:0] + 4'(DEPTH)) : diff[3:0];
      end
   end

endmodule

// File: rtl/score_history_store.sv
// Circular history of the last DEPTH finished plays, read back by logical id.
// Define SCORE_HISTORY_BEST_EN to add all-time best_score / best_user outputs.
module score_history_store
   import score_history_store_pkg::*;
#(
   parameter int DEPTH = HISTORY_DEPTH,
   parameter int ID_W  = 8
) (
   input  logic            prog_clk,
   input  logic            rst,
   input  logic            wr_valid,
   output logic            wr_ready,
   input  PlayRecord       wr_record,
   input  logic            clear_req,
   output logic            clear_done,
   input  logic [ID_W-1:0] read_record_id,
   output PlayRecord       record_data,
   output logic [3:0]      record_count
`ifdef SCORE_HISTORY_BEST_EN
   ,
   output logic [15:0]     best_score,
   output logic [7:0]      best_user
`endif
);

   localparam logic [3:0] LAST = 4'(DEPTH - 1);
   localparam logic [3:0] FULL = 4'(DEPTH);

   state_e     state_q, state_d;
   logic [3:0] wptr_q, wptr_d;
   logic [3:0] count_q, count_d;
   logic [3:0] clr_idx_q, clr_idx_d;
   logic       clear_done_q, clear_done_d;
   PlayRecord  record_data_q, record_data_d;
   PlayRecord  wr_rec_v;
   logic       wr_fire;
   logic [3:0] phys_idx;
   logic       hit;

   PlayRecord  mem [DEPTH];

`ifdef SCORE_HISTORY_BEST_EN
   logic [15:0] best_score_q, best_score_d;
   logic [7:0]  best_user_q, best_user_d;
`endif

   history_index_map #(
      .DEPTH (DEPTH),
      .ID_W  (ID_W)
   ) u_index_map (
      .wptr_i     (wptr_q),
      .count_i    (count_q),
      .k_i        (read_record_id),
      .phys_idx_o (phys_idx),
      .hit_o      (hit)
   );

   always_comb begin
      state_d        = state_q;
      wptr_d         = wptr_q;
      count_d        = count_q;
      clr_idx_d      = clr_idx_q;
      clear_done_d   = 1'b0;
      wr_ready       = (state_q == IDLE) && !clear_req;
      wr_fire        = wr_valid && wr_ready;
      wr_rec_v       = wr_record;
      wr_rec_v.valid = 1'b1;
      record_data_d  = (hit && (state_q == IDLE)) ? mem[phys_idx] : EMPTY_RECORD;
`ifdef SCORE_HISTORY_BEST_EN
      best_score_d   = best_score_q;
      best_user_d    = best_user_q;
`endif
      case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d   = CLEAR;
               wptr_d    = '0;
               count_d   = '0;
               clr_idx_d = '0;
`ifdef SCORE_HISTORY_BEST_EN
               best_score_d = '0;
               best_user_d  = '0;
`endif
            end else if (wr_fire) begin
               wptr_d  = (wptr_q == LAST) ? 4'd0 : wptr_q + 4'd1;
               count_d = (count_q == FULL) ? count_q : count_q + 4'd1;
`ifdef SCORE_HISTORY_BEST_EN
               // Strict compare: a tie leaves the earlier holder in place.
               if (wr_record.score > best_score_q) begin
                  best_score_d = wr_record.score;
                  best_user_d  = wr_record.user_id;
               end
`endif
            end
         end
         CLEAR: begin
            clr_idx_d = clr_idx_q + 4'd1;
            if (clr_idx_q == LAST) begin
               state_d      = IDLE;
               clr_idx_d    = '0;
               clear_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge prog_clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         wptr_q        <= '0;
         count_q       <= '0;
         clr_idx_q     <= '0;
         clear_done_q  <= 1'b0;
         record_data_q <= EMPTY_RECORD;
`ifdef SCORE_HISTORY_BEST_EN
         best_score_q  <= '0;
         best_user_q   <= '0;
`endif
      end else begin
         state_q       <= state_d;
         wptr_q        <= wptr_d;
         count_q       <= count_d;
         clr_idx_q     <= clr_idx_d;
         clear_done_q  <= clear_done_d;
         record_data_q <= record_data_d;
`ifdef SCORE_HISTORY_BEST_EN
         best_score_q  <= best_score_d;
         best_user_q   <= best_user_d;
`endif
      end
   end

   // Storage is not reset; count_q == 0 keeps stale slots from ever being read.
   always_ff @(posedge prog_clk) begin
      if (state_q == CLEAR) begin
         mem[clr_idx_q] <= EMPTY_RECORD;
      end else if (wr_fire) begin
         mem[wptr_q] <= wr_rec_v;
      end
   end

   assign clear_done   = clear_done_q;
   assign record_data  = record_data_q;
   assign record_count = count_q;
`ifdef SCORE_HISTORY_BEST_EN
   assign best_score   = best_score_q;
   assign best_user    = best_user_q;
`endif

endmodule

// File: tb/tb_score_history_store.sv
// Directed bench for score_history_store with a queue scoreboard for read results.
// Define SCORE_HISTORY_BEST_EN to also exercise the best-score outputs.
module tb_score_history_store;
   import score_history_store_pkg::*;

   localparam int DEPTH = 9;

   logic        prog_clk = 1'b0;
   logic        rst;
   logic        wr_valid;
   logic        wr_ready;
   PlayRecord   wr_record;
   logic        clear_req;
   logic        clear_done;
   logic [7:0]  read_record_id;
   PlayRecord   record_data;
   logic [3:0]  record_count;
`ifdef SCORE_HISTORY_BEST_EN
   logic [15:0] best_score;
   logic [7:0]  best_user;
`endif

   PlayRecord sb_q[$];
   PlayRecord hist[$];
   int        n_assert = 0;
   int        n_fail   = 0;

   always #5 prog_clk = ~prog_clk;

   score_history_store #(.DEPTH(DEPTH), .ID_W(8)) dut (
      .prog_clk       (prog_clk),
      .rst            (rst),
      .wr_valid       (wr_valid),
      .wr_ready       (wr_ready),
      .wr_record      (wr_record),
      .clear_req      (clear_req),
      .clear_done     (clear_done),
      .read_record_id (read_record_id),
      .record_data    (record_data),
      .record_count   (record_count)
`ifdef SCORE_HISTORY_BEST_EN
      ,
      .best_score     (best_score),
      .best_user      (best_user)
`endif
   );

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge prog_clk);
      #1;
   endtask

   function automatic PlayRecord mk(input logic [7:0] u, input logic [7:0] c, input logic [15:0] s);
      PlayRecord r;
      r.valid    = 1'b0;
      r.user_id  = u;
      r.chart_id = c;
      r.score    = s;
      return r;
   endfunction

   function automatic PlayRecord model_rd(input int k);
      if (k >= 1 && k <= hist.size()) return hist[k-1];
      return EMPTY_RECORD;
   endfunction

   task automatic model_wr(input PlayRecord r);
      PlayRecord v;
      v       = r;
      v.valid = 1'b1;
      hist.push_front(v);
      if (hist.size() > DEPTH) void'(hist.pop_back());
   endtask

   task automatic rd(input int k);
      PlayRecord exp;
      read_record_id = 8'(k);
      sb_q.push_back(model_rd(k));
      tick();
      exp = sb_q.pop_front();
      chk($sformatf("rd_id%0d", k), record_data, exp);
   endtask

   // Write one record while reading id k in the same cycle (read sees pre-write state).
   task automatic wr(input PlayRecord r, input int k);
      PlayRecord exp;
      wr_valid       = 1'b1;
      wr_record      = r;
      read_record_id = 8'(k);
      sb_q.push_back(model_rd(k));
      #1;
      chk("wr_ready_idle", wr_ready, 1'b1);
      tick();
      model_wr(r);
      wr_valid = 1'b0;
      exp = sb_q.pop_front();
      chk($sformatf("wr_rd_id%0d", k), record_data, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  n;
      bit  done;
      bit  saw_done;
      rst            = 1'b0;
      wr_valid       = 1'b0;
      wr_record      = EMPTY_RECORD;
      clear_req      = 1'b0;
      read_record_id = '0;
      #1;
      chk("rst_count", record_count, 4'd0);
      chk("rst_data", record_data, EMPTY_RECORD);
      chk("rst_clear_done", clear_done, 1'b0);
      chk("rst_wr_ready", wr_ready, 1'b1);
      tick();
      tick();
      rst = 1'b1;

      for (int k = 1; k <= DEPTH; k++) rd(k);

      wr(mk(8'd1, 8'd3, 16'd4487), 1);
      rd(1);
      rd(2);
      chk("count_one", record_count, 4'd1);

      for (int i = 1; i <= 10; i++) wr(mk(8'(i), 8'(i + 10), 16'(100 * i)), 1);
      chk("count_full", record_count, 4'd9);
      for (int k = 1; k <= DEPTH; k++) rd(k);
      rd(10);
      rd(0);

      // Clear requested together with a valid write: the write must not land.
      wr_record = mk(8'd7, 8'd7, 16'd7777);
      wr_valid  = 1'b1;
      clear_req = 1'b1;
      #1;
      chk("wr_ready_clr_req", wr_ready, 1'b0);
      tick();
      wr_valid  = 1'b0;
      clear_req = 1'b0;
      hist.delete();
      chk("clr_count_zero", record_count, 4'd0);
      n    = 0;
      done = 1'b0;
      while (!done && n < 20) begin
         tick();
         n++;
         clear_req = (n == 3);
         if (n == 5) chk("wr_ready_clear", wr_ready, 1'b0);
         if (clear_done) done = 1'b1;
      end
      clear_req = 1'b0;
      chk("clr_done_seen", done, 1'b1);
      chk("clr_latency", n, 9);
      tick();
      chk("clr_done_pulse", clear_done, 1'b0);
      for (int k = 1; k <= DEPTH; k++) rd(k);
      chk("clr_count", record_count, 4'd0);

      wr(mk(8'd9, 8'd9, 16'd999), 1);
      rd(1);
      rd(2);

      // Reset in the middle of a clear sweep.
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      hist.delete();
      tick();
      tick();
      tick();
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_count", record_count, 4'd0);
      chk("mid_rst_data", record_data, EMPTY_RECORD);
      chk("mid_rst_clear_done", clear_done, 1'b0);
      chk("mid_rst_wr_ready", wr_ready, 1'b1);
      saw_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (clear_done) saw_done = 1'b1;
      end
      rst = 1'b1;
      wr(mk(8'd5, 8'd5, 16'd555), 1);
      for (int i = 0; i < 12; i++) begin
         if (clear_done) saw_done = 1'b1;
         if (i < 11) rd(2);
      end
      chk("mid_rst_no_done", saw_done, 1'b0);
      chk("post_rst_count", record_count, 4'd1);
      rd(1);

`ifdef SCORE_HISTORY_BEST_EN
      rst = 1'b0;
      hist.delete();
      tick();
      rst = 1'b1;
      chk("best_rst", best_score, 16'd0);
      wr(mk(8'd1, 8'd1, 16'd500), 1);
      wr(mk(8'd2, 8'd1, 16'd800), 1);
      wr(mk(8'd3, 8'd1, 16'd800), 1);
      chk("best_score", best_score, 16'd800);
      chk("best_user", best_user, 8'd2);
      for (int i = 0; i < 9; i++) wr(mk(8'd4, 8'd1, 16'd10), 1);
      chk("best_score_evict", best_score, 16'd800);
      chk("best_user_evict", best_user, 8'd2);
      rd(9);
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      hist.delete();
      chk("best_clear", best_score, 16'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
